// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter muxing NREQ word streams onto a single FIFO write port.
// Latency: grant one cycle after a request in IDLE; data passes through combinationally.
// Backpressure: fifo_full drops req_ready/fifo_wr_en and freezes the grant and burst count.
module fifo_wr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   input  logic [NREQ-1:0]         req_last,
   output logic [NREQ-1:0]         req_ready,
   input  logic                    fifo_full,
   output logic                    fifo_wr_en,
   output logic [WIDTH-1:0]        fifo_wr_data,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy
);

   localparam int IDW = $clog2(NREQ);

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] owner_q, owner_d;
   logic [IDW-1:0] rr_q, rr_d;
   logic [IDW-1:0] sel;
   logic [IDW-1:0] owner_inc;
   logic [3:0]     cnt_q, cnt_d, cnt_inc;
   logic           any_vld;
   logic           own_vld;
   logic           own_last;

   assign any_vld   = |req_valid;
   assign own_vld   = req_valid[owner_q];
   assign own_last  = req_last[owner_q];
   assign owner_inc = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
   assign cnt_inc   = cnt_q + 4'd1;

   // First valid requester at or above rr_ptr, wrapping past NREQ-1 back to 0.
   always_comb begin : arb_search
      logic found;
      int   idx;
      found = 1'b0;
      idx   = 0;
      sel   = rr_q;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(rr_q) + i) % NREQ;
         if (!found && req_valid[idx]) begin
            sel   = IDW'(idx);
            found = 1'b1;
         end
      end
   end

   // Datapath and handshake outputs, all driven from the current owner.
   always_comb begin
      busy         = (state_q == LOCK);
      fifo_wr_en   = busy & own_vld & ~fifo_full;
      fifo_wr_data = req_data[int'(owner_q)*WIDTH +: WIDTH];
      grant_id     = owner_q;
      req_ready    = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = busy && (IDW'(i) == owner_q) && !fifo_full;
      end
   end

   // Next-state: grant in IDLE, release in LOCK on last word, burst cap or withdrawal.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (any_vld) begin
               state_d = LOCK;
               owner_d = sel;
               cnt_d   = 4'd0;
            end
         end
         LOCK: begin
            // A full FIFO freezes everything, including withdrawal detection.
            if (!fifo_full) begin
               if (!own_vld) begin
                  state_d = IDLE;
                  rr_d    = owner_inc;
               end else begin
                  cnt_d = cnt_inc;
                  if (own_last || (cnt_inc == 4'(MAX_BURST))) begin
                     state_d = IDLE;
                     rr_d    = owner_inc;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any grant immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q    <= '0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with NREQ=4, WIDTH=8, MAX_BURST=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Each scenario task resets the DUT first so rr_ptr starts at 0.
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [7:0]  fifo_wr_data;
   logic [1:0]  grant_id;
   logic        busy;

   int tests_run    = 0;
   int tests_failed = 0;

   fifo_wr_arbiter #(.WIDTH(8), .NREQ(4), .MAX_BURST(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .grant_id     (grant_id),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      fifo_full = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set_data(input int i, input logic [7:0] v);
      req_data[i*8 +: 8] = v;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      req_data  = 32'hDDCCBBAA;
      fifo_full = 1'b0;
      tick();
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
         $display("FAIL reset_busy: got %b want 0", busy); tests_failed++;
      end
      tests_run++;
      if (fifo_wr_en !== 1'b0) begin
         $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); tests_failed++;
      end
      tests_run++;
      if (req_ready !== 4'b0000) begin
         $display("FAIL reset_ready: got %b want 0000", req_ready); tests_failed++;
      end
      tests_run++;
      if (grant_id !== 2'd0) begin
         $display("FAIL reset_grant: got %0d want 0", grant_id); tests_failed++;
      end
   endtask

   task automatic test_single();
      logic [7:0] words [3];
      words[0] = 8'hA1; words[1] = 8'hA2; words[2] = 8'hA3;
      do_reset();
      req_valid = 4'b0010;
      set_data(1, words[0]);
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
         $display("FAIL single_idle: busy got %b want 0", busy); tests_failed++;
      end
      for (int w = 0; w < 3; w++) begin
         tick();
         set_data(1, words[w]);
         req_last = (w == 2) ? 4'b0010 : 4'b0000;
         @(negedge clk);
         tests_run++;
         if (grant_id !== 2'd1 || busy !== 1'b1 || req_ready !== 4'b0010) begin
            $display("FAIL single_grant w%0d: grant %0d busy %b ready %b want 1 1 0010",
                     w, grant_id, busy, req_ready);
            tests_failed++;
         end
         tests_run++;
         if (fifo_wr_en !== 1'b1 || fifo_wr_data !== words[w]) begin
            $display("FAIL single_write w%0d: wr_en %b data %h want 1 %h",
                     w, fifo_wr_en, fifo_wr_data, words[w]);
            tests_failed++;
         end
      end
      // Released: one IDLE cycle, then rr_ptr=2 must pick 2 over 1.
      tick();
      req_last  = 4'b0000;
      req_valid = 4'b0110;
      set_data(2, 8'hB2);
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
         $display("FAIL single_release: busy %b wr_en %b want 0 0", busy, fifo_wr_en);
         tests_failed++;
      end
      tick();
      @(negedge clk);
      tests_run++;
      if (grant_id !== 2'd2 || busy !== 1'b1) begin
         $display("FAIL single_rrptr: grant %0d busy %b want 2 1", grant_id, busy);
         tests_failed++;
      end
   endtask

   task automatic test_round_robin();
      int g;
      do_reset();
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      for (int i = 0; i < 4; i++) set_data(i, 8'(8'h10 + i));
      for (int c = 0; c < 10; c++) begin
         if (c != 0) tick();
         @(negedge clk);
         if (c % 2 == 0) begin
            tests_run++;
            if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
               $display("FAIL rr_idle c%0d: busy %b wr_en %b want 0 0", c, busy, fifo_wr_en);
               tests_failed++;
            end
         end else begin
            g = ((c - 1) / 2) % 4;
            tests_run++;
            if (busy !== 1'b1 || grant_id !== 2'(g)) begin
               $display("FAIL rr_grant c%0d: busy %b grant %0d want 1 %0d", c, busy, grant_id, g);
               tests_failed++;
            end
            tests_run++;
            if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'(8'h10 + g)) begin
               $display("FAIL rr_data c%0d: wr_en %b data %h want 1 %h",
                        c, fifo_wr_en, fifo_wr_data, 8'(8'h10 + g));
               tests_failed++;
            end
         end
      end
   endtask

   task automatic test_burst_cap();
      do_reset();
      req_valid = 4'b1100;
      set_data(3, 8'h3F);
      set_data(2, 8'h20);
      @(negedge clk);
      for (int w = 0; w < 4; w++) begin
         tick();
         set_data(2, 8'(8'h20 + w));
         @(negedge clk);
         tests_run++;
         if (busy !== 1'b1 || grant_id !== 2'd2 || fifo_wr_en !== 1'b1 ||
             fifo_wr_data !== 8'(8'h20 + w)) begin
            $display("FAIL burst_w%0d: busy %b grant %0d wr_en %b data %h want 1 2 1 %h",
                     w, busy, grant_id, fifo_wr_en, fifo_wr_data, 8'(8'h20 + w));
            tests_failed++;
         end
      end
      tick();
      set_data(2, 8'h24);
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
         $display("FAIL burst_release: busy %b wr_en %b want 0 0", busy, fifo_wr_en);
         tests_failed++;
      end
      tick();
      @(negedge clk);
      tests_run++;
      if (grant_id !== 2'd3 || busy !== 1'b1 || fifo_wr_data !== 8'h3F) begin
         $display("FAIL burst_next: grant %0d busy %b data %h want 3 1 3f",
                  grant_id, busy, fifo_wr_data);
         tests_failed++;
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      req_valid = 4'b0001;
      set_data(0, 8'h30);
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         tick();
         set_data(0, 8'(8'h30 + w));
         @(negedge clk);
         tests_run++;
         if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'(8'h30 + w)) begin
            $display("FAIL bp_pre w%0d: wr_en %b data %h want 1 %h",
                     w, fifo_wr_en, fifo_wr_data, 8'(8'h30 + w));
            tests_failed++;
         end
      end
      for (int f = 0; f < 3; f++) begin
         tick();
         set_data(0, 8'h32);
         fifo_full = 1'b1;
         req_last  = (f == 1) ? 4'b0001 : 4'b0000;
         @(negedge clk);
         tests_run++;
         if (req_ready !== 4'b0000 || fifo_wr_en !== 1'b0 || busy !== 1'b1 ||
             grant_id !== 2'd0) begin
            $display("FAIL bp_full f%0d: ready %b wr_en %b busy %b grant %0d want 0000 0 1 0",
                     f, req_ready, fifo_wr_en, busy, grant_id);
            tests_failed++;
         end
      end
      // Burst count was held at 2: two more writes reach the cap of 4.
      for (int w = 2; w < 4; w++) begin
         tick();
         fifo_full = 1'b0;
         req_last  = 4'b0000;
         set_data(0, 8'(8'h30 + w));
         @(negedge clk);
         tests_run++;
         if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'(8'h30 + w) || req_ready !== 4'b0001) begin
            $display("FAIL bp_resume w%0d: wr_en %b data %h ready %b want 1 %h 0001",
                     w, fifo_wr_en, fifo_wr_data, req_ready, 8'(8'h30 + w));
            tests_failed++;
         end
      end
      tick();
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
         $display("FAIL bp_release: busy %b wr_en %b want 0 0", busy, fifo_wr_en);
         tests_failed++;
      end
   endtask

   task automatic test_withdraw();
      do_reset();
      req_valid = 4'b0011;
      set_data(0, 8'h40);
      set_data(1, 8'h41);
      @(negedge clk);
      tick();
      @(negedge clk);
      tests_run++;
      if (grant_id !== 2'd0 || fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h40) begin
         $display("FAIL wd_first: grant %0d wr_en %b data %h want 0 1 40",
                  grant_id, fifo_wr_en, fifo_wr_data);
         tests_failed++;
      end
      tick();
      req_valid = 4'b0010;
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b1 || fifo_wr_en !== 1'b0) begin
         $display("FAIL wd_drop: busy %b wr_en %b want 1 0", busy, fifo_wr_en);
         tests_failed++;
      end
      tick();
      req_valid = 4'b0011;
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
         $display("FAIL wd_release: busy %b want 0", busy); tests_failed++;
      end
      tick();
      @(negedge clk);
      tests_run++;
      if (grant_id !== 2'd1 || busy !== 1'b1 || fifo_wr_data !== 8'h41) begin
         $display("FAIL wd_rrptr: grant %0d busy %b data %h want 1 1 41",
                  grant_id, busy, fifo_wr_data);
         tests_failed++;
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 4'b0100;
      set_data(2, 8'h50);
      set_data(0, 8'h5A);
      @(negedge clk);
      tick();
      @(negedge clk);
      tick();
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b1 || grant_id !== 2'd2) begin
         $display("FAIL rm_locked: busy %b grant %0d want 1 2", busy, grant_id);
         tests_failed++;
      end
      #1 rst_n = 1'b0;
      #1;
      tests_run++;
      if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0000 || grant_id !== 2'd0) begin
         $display("FAIL rm_async: busy %b wr_en %b ready %b grant %0d want 0 0 0000 0",
                  busy, fifo_wr_en, req_ready, grant_id);
         tests_failed++;
      end
      tick();
      rst_n     = 1'b1;
      req_valid = 4'b1001;
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
         $display("FAIL rm_idle: busy %b wr_en %b want 0 0", busy, fifo_wr_en);
         tests_failed++;
      end
      tick();
      @(negedge clk);
      tests_run++;
      if (grant_id !== 2'd0 || busy !== 1'b1 || fifo_wr_data !== 8'h5A) begin
         $display("FAIL rm_first: grant %0d busy %b data %h want 0 1 5a",
                  grant_id, busy, fifo_wr_data);
         tests_failed++;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      fifo_full = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_burst_cap();
      test_backpressure();
      test_withdraw();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, data width of each requester and of the FIFO write port.
REQ-002 The module SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 The module SHALL have parameter MAX_BURST, default 4, maximum words per grant (1..15).
REQ-004 The module SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 The module SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 The module SHALL have port req_valid, input, NREQ, per-requester word-available flag.
REQ-007 The module SHALL have port req_data, input, NREQ*WIDTH, requester i data in bits [i*WIDTH +: WIDTH].
REQ-008 The module SHALL have port req_last, input, NREQ, word is the last of a packet.
REQ-009 The module SHALL have port req_ready, output, NREQ, per-requester word-accepted qualifier.
REQ-010 The module SHALL have port fifo_full, input, 1, full flag from the FIFO write side.
REQ-011 The module SHALL have port fifo_wr_en, output, 1, FIFO write strobe.
REQ-012 The module SHALL have port fifo_wr_data, output, WIDTH, FIFO write data.
REQ-013 The module SHALL have port grant_id, output, clog2(NREQ), index of the current owner.
REQ-014 The module SHALL have port busy, output, 1, high while a grant is held.

Function
REQ-015 The FSM SHALL have two states: IDLE (arbitrate) and LOCK (owner transfers).
REQ-016 In IDLE with any req_valid high, the FSM SHALL select the first valid index searching upward from rr_ptr with wrap (NREQ-1 -> 0), load owner and enter LOCK next edge.
REQ-017 In IDLE with no req_valid high, the FSM SHALL stay in IDLE and leave owner and rr_ptr unchanged.
REQ-018 Combinational outputs: req_ready[i] = (state==LOCK) & (i==owner) & !fifo_full; all other req_ready bits SHALL be 0.
REQ-019 fifo_wr_en SHALL equal req_valid[owner] & req_ready[owner]; fifo_wr_data SHALL equal req_data[owner] (zero added latency, one word per cycle).
REQ-020 No write SHALL be issued while fifo_full is high, whatever the requester does.
REQ-021 A transfer SHALL increment burst_cnt (4 bits); burst_cnt SHALL clear on entry to LOCK.
REQ-022 LOCK SHALL release to IDLE on the edge ending a transfer with req_last[owner]=1, or a transfer bringing burst_cnt to MAX_BURST.
REQ-023 LOCK SHALL also release when req_valid[owner]=0 for one cycle (requester withdrew).
REQ-024 On every release, rr_ptr SHALL become owner+1 modulo NREQ.
REQ-025 fifo_full high in LOCK SHALL hold state, owner and burst_cnt; it SHALL NOT count toward release.
REQ-026 Release and re-arbitration SHALL be separated by exactly one IDLE cycle (no back-to-back grants).
REQ-027 grant_id SHALL equal owner; busy SHALL equal (state==LOCK).
REQ-028 Changes on req_valid of non-owners during LOCK SHALL have no effect until the next IDLE.

Reset
REQ-029 On rst_n low, the block SHALL immediately enter IDLE with owner=0, rr_ptr=0, burst_cnt=0.
REQ-030 During reset, fifo_wr_en, req_ready, busy and grant_id SHALL be 0.
REQ-031 Reset asserted mid-burst SHALL abort the grant with no further write; the first post-reset arbitration starts at index 0.

Verification
REQ-032 Single requester: req_valid=4'b0010, 3 words 0xA1,0xA2,0xA3 (last on 0xA3) -> grant_id=1 one cycle later, three consecutive fifo_wr_en with those data, then IDLE, rr_ptr=2.
REQ-033 Round robin: all four valid continuously, single-word packets -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-034 Burst cap: MAX_BURST=4, requester 2 streams 10 words with no last -> release after 4 writes; requester 3 (if valid) granted next.
REQ-035 Backpressure: fifo_full high 3 cycles mid-burst -> req_ready=0, fifo_wr_en=0 during those cycles; burst_cnt held; transfer resumes with the same word.
REQ-036 Withdrawal: owner 0 drops req_valid after 1 word -> release next edge, rr_ptr=1.
REQ-037 Reset mid-burst: rst_n low during LOCK -> outputs 0 asynchronously; after release, requesters 0 and 3 valid -> requester 0 granted first.
